pipeline_stage_reg: RTL
=======================

# pipeline_stage_reg

Generic, parametrised inter-stage pipeline register that replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries a control field and an opaque data field between two stages. It adds what the fixed registers lack: a valid/ready handshake, back-pressure (stall), flush with bubble insertion, and an optional skid slot for full throughput under a registered ready.

## Interface
Parameters:
- CTRL_W, 16, width of control-signal field; zeroed for bubbles.
- DATA_W, 84, width of payload (result, address, dst num, dst value, SP concatenated by instantiator).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and same-cycle input.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control signals.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  block presents an entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  held control signals; 0 when out_valid=0.
- out_data  out  DATA_W  held payload; holds its last value when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Accept (in_fire) = in_valid & in_ready. Consume (out_fire) = out_valid & out_ready.
- Two storage slots: main (drives outputs) and skid (only with PIPE_REG_SKID_EN).
- States: EMPTY (occ 0), ONE (main valid, occ 1), FULL (main+skid valid, occ 2).
- EMPTY: in_fire -> main <= in, go ONE.
- ONE: in_fire & out_fire -> main <= in, stay ONE. in_fire only -> skid <= in, go FULL. out_fire only -> go EMPTY.
- FULL: in_ready=0. out_fire -> main <= skid, go ONE. Otherwise hold.
- Priority: reset > flush > normal transitions.
- flush=1: next state EMPTY. Main and skid valid cleared. Any same-cycle in_fire is discarded; upstream must treat it as consumed. out_fire on a flush cycle is still a legal consume of the current entry.
- out_ctrl is forced to 0 whenever out_valid=0, so downstream sees a NOP bubble. out_data is not cleared; it is don't-care when out_valid=0.
- Ordering: entries leave in acceptance order; no entry is duplicated or dropped except by flush or reset.
- Reset values: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 with skid; in_ready=1 without skid (main empty).

## Timing
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N.
- Throughput: 1 entry/cycle while out_ready=1 continuously.
- With skid: in_ready = !skid_valid, a pure register output with no combinational path from out_ready.
- Without skid: in_ready = !main_valid | out_ready, a combinational path from out_ready.
- Stall: out_ready=0 holds out_* stable, with no change in value while out_valid=1.
- Reset asserted mid-transfer: all entries dropped at that edge; in_fire in the reset cycle is ignored.

## Configuration
- PIPE_REG_SKID_EN defined: skid slot, FULL state and registered in_ready present; occupancy reaches 2.
- Undefined: no skid slot; states EMPTY/ONE only; combinational in_ready; occupancy max 1. All other behaviour is identical.

## Structure
- Shared package pipeline_pkg:
  - state encoding typedef (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2).
  - NOP control constant (all zeros).
  - Default field widths, reused by all stage instantiations.
- Sub-module pipe_slot: valid + ctrl + data register with load and clear inputs. It is instantiated once for main and once for skid, under the macro.
- Top holds the state machine, in_ready/out_valid logic and the out_ctrl bubble mux.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0 after release.
- Streaming: out_ready=1, send ctrl 16'h0001..16'h0004 on consecutive cycles -> emerge in order, one cycle later each, in_ready stays 1.
- Stall (skid on): out_ready=0, send A then B -> occupancy 2 and in_ready=0 after B, out_ctrl=A stable. Raise out_ready -> A, then B, occupancy returns to 0.
- Flush while FULL with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=16'h0000, occupancy=0, C never appears.
- Skid off: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> in_ready=1 in the same cycle and the entry is replaced without a bubble.
- Random valid/ready with scoreboard, 10k cycles -> no loss, duplication or reordering; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the generic inter-stage pipeline register.
// The skid-slot build is selected with the PIPE_REG_SKID_EN macro in the top.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam int CTRL_W_DEF = 16;
   localparam int DATA_W_DEF = 84;

   localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

   function automatic logic [1:0] occ_of(input state_t s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: valid flag plus control and data.
// Reset clears everything; clear drops only the valid flag so data holds.
module pipe_slot #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 84
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] load_ctrl,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= load_ctrl;
         data  <= load_data;
      end
   end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic valid/ready pipeline register with stall, flush and bubble insertion.
// Define PIPE_REG_SKID_EN for a skid slot and a purely registered in_ready.
module pipeline_stage_reg
   import pipeline_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   state_t state_reg, state_next;

   logic              main_valid;
   logic              main_load;
   logic              main_clear;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_load_ctrl;
   logic [DATA_W-1:0] main_load_data;
   logic              in_fire;
   logic              out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(NOP_CTRL);
   assign out_data  = main_data;
   assign occupancy = occ_of(state_reg);

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_EMPTY;
      else       state_reg <= state_next;
   end

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .load_ctrl (main_load_ctrl),
      .load_data (main_load_data),
      .valid     (main_valid),
      .ctrl      (main_ctrl),
      .data      (main_data)
   );

`ifdef PIPE_REG_SKID_EN
   logic              skid_valid;
   logic              skid_load;
   logic              skid_clear;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   // Registered ready: the upstream never sees a path from out_ready.
   assign in_ready = !skid_valid;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
   );

   always_comb begin
      state_next     = state_reg;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      main_load_ctrl = in_ctrl;
      main_load_data = in_data;
      if (flush) begin
         state_next = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_load  = 1'b1;
                  state_next = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  skid_load  = 1'b1;
                  state_next = ST_FULL;
               end else if (out_fire) begin
                  main_clear = 1'b1;
                  state_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // Promote the skid entry so ordering is preserved.
               if (out_fire) begin
                  main_load      = 1'b1;
                  main_load_ctrl = skid_ctrl;
                  main_load_data = skid_data;
                  skid_clear     = 1'b1;
                  state_next     = ST_ONE;
               end
            end
            default: begin
               state_next = ST_EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end
`else
   // Ready looks through to out_ready so a held entry can be replaced in place.
   assign in_ready = !main_valid | out_ready;

   always_comb begin
      state_next     = state_reg;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_load_ctrl = in_ctrl;
      main_load_data = in_data;
      if (flush) begin
         state_next = ST_EMPTY;
         main_clear = 1'b1;
      end else if (in_fire) begin
         main_load  = 1'b1;
         state_next = ST_ONE;
      end else if (out_fire) begin
         main_clear = 1'b1;
         state_next = ST_EMPTY;
      end
   end
`endif

endmodule
